pulse_interval_meter: RTL and testbench

Measures the time between a start pulse and a stop pulse in clk ticks (20 ns at the 50 MHz system clock). The result uses the same cycle accounting as the fixed delay lines: a delay line fed `start` and returning its output as `stop` reads back exactly its tap count. For example, a 200 ns line reads 10 and a 1 µs line reads 50. Used for bench self-checks of the delay lines and for run-time measurement of I/O device pulse spacing in the PDP-1 model.

---
 rtl/pulse_interval_meter.sv | 160 ++++++++++++++++
 tb/tb_pulse_interval_meter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_interval_meter.sv
// Start-to-stop interval meter counting clk ticks, with retrigger, timeout and clear.
// Optional running min/max of captured intervals when PULSE_METER_MINMAX_EN is defined.
module pulse_interval_meter #(
    parameter int W       = 16,
    parameter int TIMEOUT = 25000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         clr,
    output logic         busy,
    output logic         done,
    output logic         valid,
    output logic [W-1:0] interval,
    output logic         timeout
`ifdef PULSE_METER_MINMAX_EN
    ,
    output logic [W-1:0] min_iv,
    output logic [W-1:0] max_iv
`endif
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   interval_q, interval_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;
    logic           timeout_q, timeout_d;
    logic           capture_s;
    logic           expire_s;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= {W{1'b0}};
            interval_q <= {W{1'b0}};
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            interval_q <= interval_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next state and counter; a simultaneous start/stop in RUN captures then restarts
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        expire_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = {{(W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RUN: begin
                if (stop) begin
                    capture_s = 1'b1;
                    if (start) begin
                        cnt_d = {{(W-1){1'b0}}, 1'b1};
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start) begin
                    cnt_d = {{(W-1){1'b0}}, 1'b1};
                end else if (cnt_q == W'(TIMEOUT)) begin
                    expire_s = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {W{1'b0}};
            end
        endcase
    end

    // Result registers; a capture takes priority over clr
    always_comb begin
        done_d     = capture_s;
        timeout_d  = expire_s;
        interval_d = interval_q;
        valid_d    = valid_q;
        if (capture_s) begin
            interval_d = cnt_q;
            valid_d    = 1'b1;
        end else if (clr) begin
            interval_d = {W{1'b0}};
            valid_d    = 1'b0;
        end else begin
            interval_d = interval_q;
            valid_d    = valid_q;
        end
    end

    // Outputs straight from registers
    always_comb begin
        busy     = (state_q == RUN);
        done     = done_q;
        valid    = valid_q;
        interval = interval_q;
        timeout  = timeout_q;
    end

`ifdef PULSE_METER_MINMAX_EN
    logic [W-1:0] min_q, min_d;
    logic [W-1:0] max_q, max_d;

    // Running extremes; a capture coinciding with clr seeds both with the new value
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (capture_s) begin
            if (clr) begin
                min_d = cnt_q;
                max_d = cnt_q;
            end else begin
                min_d = (cnt_q < min_q) ? cnt_q : min_q;
                max_d = (cnt_q > max_q) ? cnt_q : max_q;
            end
        end else if (clr) begin
            min_d = {W{1'b1}};
            max_d = {W{1'b0}};
        end else begin
            min_d = min_q;
            max_d = max_q;
        end
    end

    // Extreme registers
    always_ff @(posedge clk) begin
        if (reset) begin
            min_q <= {W{1'b1}};
            max_q <= {W{1'b0}};
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_iv = min_q;
    assign max_iv = max_q;
`endif

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Directed self-checking bench for pulse_interval_meter: one short-timeout instance
// (TIMEOUT=100) and one default instance (TIMEOUT=25000) sharing the same stimulus.
module tb_pulse_interval_meter;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic clr = 1'b0;

    logic busy_a, done_a, valid_a, timeout_a;
    logic [W-1:0] interval_a;
    logic busy_b, done_b, valid_b, timeout_b;
    logic [W-1:0] interval_b;
`ifdef PULSE_METER_MINMAX_EN
    logic [W-1:0] min_a, max_a, min_b, max_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic long_to_seen = 1'b0;

    always #10 clk = ~clk;

    pulse_interval_meter #(.W(W), .TIMEOUT(100)) dut_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clr(clr),
        .busy(busy_a), .done(done_a), .valid(valid_a), .interval(interval_a),
        .timeout(timeout_a)
`ifdef PULSE_METER_MINMAX_EN
        , .min_iv(min_a), .max_iv(max_a)
`endif
    );

    pulse_interval_meter #(.W(W), .TIMEOUT(25000)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clr(clr),
        .busy(busy_b), .done(done_b), .valid(valid_b), .interval(interval_b),
        .timeout(timeout_b)
`ifdef PULSE_METER_MINMAX_EN
        , .min_iv(min_b), .max_iv(max_b)
`endif
    );

    always @(posedge clk) begin
        if (timeout_b) long_to_seen <= 1'b1;
    end

    // Apply inputs at negedge, let the posedge sample them, look at outputs 1 ns later
    task automatic cyc(input logic s, input logic p, input logic c);
        @(negedge clk);
        start = s;
        stop  = p;
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Compare every output of dut_a against expected values
    task automatic chk_a(input string nm, input logic eb, input logic ed, input logic ev,
                         input logic [W-1:0] ei, input logic et);
        n_cmp++;
        if ({busy_a, done_a, valid_a, interval_a, timeout_a} !== {eb, ed, ev, ei, et}) begin
            n_bad++;
            $display("FAIL %s: got busy=%b done=%b valid=%b interval=%0d timeout=%b, want busy=%b done=%b valid=%b interval=%0d timeout=%b",
                     nm, busy_a, done_a, valid_a, interval_a, timeout_a, eb, ed, ev, ei, et);
        end
    endtask

    task automatic test_reset;
        idle(2);
        chk_a("reset_a", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        n_cmp++;
        if ({busy_b, done_b, valid_b, interval_b, timeout_b} !== {1'b0, 1'b0, 1'b0, 16'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_b: got %b%b%b %0d %b, want all 0", busy_b, done_b, valid_b, interval_b, timeout_b);
        end
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        chk_a("idle_stop_ignored", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic test_basic;
        logic busy_ok = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (busy_a !== 1'b1 || done_a !== 1'b0) busy_ok = 1'b0;
            cyc(1'b0, 1'b0, 1'b0);
        end
        if (busy_a !== 1'b1 || done_a !== 1'b0) busy_ok = 1'b0;
        n_cmp++;
        if (busy_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_busy: got busy_window_ok=%b want 1", busy_ok);
        end
        cyc(1'b0, 1'b1, 1'b0);
        chk_a("basic_capture", 1'b0, 1'b1, 1'b1, 16'd10, 1'b0);
        idle(1);
        chk_a("basic_done_drop", 1'b0, 1'b0, 1'b1, 16'd10, 1'b0);
    endtask

    task automatic test_min_interval;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk_a("min_n1", 1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
    endtask

    task automatic test_retrigger;
        cyc(1'b1, 1'b0, 1'b0);          // t=0
        idle(3);
        cyc(1'b1, 1'b0, 1'b0);          // t=4
        chk_a("retrig_no_result", 1'b1, 1'b0, 1'b1, 16'd1, 1'b0);
        idle(4);
        cyc(1'b0, 1'b1, 1'b0);          // t=9
        chk_a("retrig_capture", 1'b0, 1'b1, 1'b1, 16'd5, 1'b0);
        idle(2);
        cyc(1'b1, 1'b0, 1'b0);          // t=12
        idle(7);
        cyc(1'b1, 1'b1, 1'b0);          // t=20
        chk_a("simul_capture", 1'b1, 1'b1, 1'b1, 16'd8, 1'b0);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0);          // t=23
        chk_a("simul_restart", 1'b0, 1'b1, 1'b1, 16'd3, 1'b0);
    endtask

    task automatic test_back_to_back;
        cyc(1'b1, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 1'b1, 1'b0);
        chk_a("b2b_first", 1'b1, 1'b1, 1'b1, 16'd2, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk_a("b2b_second", 1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
    endtask

    task automatic test_timeout;
        cyc(1'b1, 1'b0, 1'b0);
        idle(99);
        chk_a("to_before", 1'b1, 1'b0, 1'b1, 16'd1, 1'b0);
        idle(1);
        chk_a("to_pulse", 1'b0, 1'b0, 1'b1, 16'd1, 1'b1);
        idle(1);
        chk_a("to_drop", 1'b0, 1'b0, 1'b1, 16'd1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        idle(99);
        cyc(1'b0, 1'b1, 1'b0);
        chk_a("stop_at_timeout", 1'b0, 1'b1, 1'b1, 16'd100, 1'b0);
        idle(1);
        chk_a("stop_at_timeout_after", 1'b0, 1'b0, 1'b1, 16'd100, 1'b0);
    endtask

    task automatic test_loopback;
        cyc(1'b1, 1'b0, 1'b0);
        idle(49);
        cyc(1'b0, 1'b1, 1'b0);
        chk_a("loop_1us", 1'b0, 1'b1, 1'b1, 16'd50, 1'b0);
        @(negedge clk);
        long_to_seen = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        idle(24999);
        cyc(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({done_b, valid_b, interval_b, busy_b} !== {1'b1, 1'b1, 16'd25000, 1'b0}) begin
            n_bad++;
            $display("FAIL loop_500us: got done=%b valid=%b interval=%0d busy=%b, want 1 1 25000 0",
                     done_b, valid_b, interval_b, busy_b);
        end
        idle(1);
        n_cmp++;
        if (long_to_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL loop_500us_no_timeout: got timeout_seen=%b want 0", long_to_seen);
        end
    endtask

    task automatic test_clear;
        cyc(1'b0, 1'b0, 1'b1);
        chk_a("clr", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b1, 1'b1);
        chk_a("clr_vs_capture", 1'b0, 1'b1, 1'b1, 16'd2, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk_a("clr_keeps_fsm", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_a("reset_mid_run", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        chk_a("stop_after_reset", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

`ifdef PULSE_METER_MINMAX_EN
    task automatic test_minmax;
        cyc(1'b1, 1'b0, 1'b0); idle(6);  cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0); idle(2);  cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0); idle(11); cyc(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (min_a !== 16'd3 || max_a !== 16'd12) begin
            n_bad++;
            $display("FAIL minmax: got min=%0d max=%0d want 3 12", min_a, max_a);
        end
        cyc(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (min_a !== 16'hFFFF || max_a !== 16'd0) begin
            n_bad++;
            $display("FAIL minmax_clr: got min=%h max=%h want ffff 0", min_a, max_a);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_min_interval;
        test_retrigger;
        test_back_to_back;
        test_timeout;
        test_loopback;
        test_clear;
`ifdef PULSE_METER_MINMAX_EN
        test_minmax;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
